// File: rtl/cim_macro_model_pkg.sv
// Shared types and the column quantiser for the CIM macro model.
package cim_macro_model_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_EVAL,
        S_CONVERT,
        S_DONE
    } cim_state_e;

    // Round-half-up arithmetic shift, then saturate to a signed code of 'bits' width.
    function automatic int sat_round_shift(input int sum, input int unsigned shift,
                                           input int unsigned bits);
        int rnd;
        int hi;
        int lo;
        hi = (1 << (bits - 1)) - 1;
        lo = -(1 << (bits - 1));
        if (shift > 0) begin
            rnd = (sum + (1 << (shift - 1))) >>> shift;
        end else begin
            rnd = sum;
        end
        if (rnd > hi) begin
            return hi;
        end else if (rnd < lo) begin
            return lo;
        end
        return rnd;
    endfunction

endpackage

// File: rtl/cim_macro_model_col_adc.sv
// One bitline column: binary weight storage, signed dot product and ADC quantiser.
module cim_macro_model_col_adc
    import cim_macro_model_pkg::*;
#(
    parameter int unsigned INPUT_ELEMENTS = 128,
    parameter int unsigned ADC_BITS       = 4,
    parameter int unsigned ADC_SHIFT      = 3
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      wr_en_i,
    input  logic [INPUT_ELEMENTS-1:0] wr_data_i,
    input  logic [INPUT_ELEMENTS-1:0] wl_i,
    input  logic                      eval_i,
    input  logic                      done_i,
    output logic [ADC_BITS-1:0]       adc_o
);

    localparam int unsigned SUM_W = $clog2(INPUT_ELEMENTS) + 2;

    logic [INPUT_ELEMENTS-1:0] w_q;
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [SUM_W-1:0]   sum_q;
    logic [ADC_BITS-1:0]       adc_q;

    // Active wordlines add +1 where the weight bit is set and -1 where it is clear.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < INPUT_ELEMENTS; i++) begin
            if (wl_i[i]) begin
                sum_d = w_q[i] ? (sum_d + SUM_W'(1)) : (sum_d - SUM_W'(1));
            end
        end
    end

    // Weight write, sum capture in EVAL and code update in DONE.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            w_q   <= '0;
            sum_q <= '0;
            adc_q <= '0;
        end else begin
            if (wr_en_i) begin
                w_q <= wr_data_i;
            end
            if (eval_i) begin
                sum_q <= sum_d;
            end
            if (done_i) begin
                adc_q <= ADC_BITS'(sat_round_shift(int'(sum_q), ADC_SHIFT, ADC_BITS));
            end
        end
    end

    assign adc_o = adc_q;

endmodule

// File: rtl/cim_macro_model.sv
// Cycle-accurate model of the analog CIM macro: sequencing FSM, bit-plane latch,
// weight write decode and an array of column ADCs.
module cim_macro_model
    import cim_macro_model_pkg::*;
#(
    parameter int unsigned INPUT_ELEMENTS  = 128,
    parameter int unsigned OUTPUT_ELEMENTS = 32,
    parameter int unsigned ADC_BITS        = 4,
    parameter int unsigned ADC_SHIFT       = 3,
    parameter int unsigned CONV_CYCLES     = 2
) (
    input  logic                                      clk,
    input  logic                                      nrst,
    input  logic [INPUT_ELEMENTS-1:0]                 wl_bits_i,
    input  logic                                      wl_valid_i,
    output logic                                      wl_ready_o,
    output logic [OUTPUT_ELEMENTS-1:0][ADC_BITS-1:0]  adc_o,
    output logic                                      adc_valid_o,
    input  logic                                      wr_en_i,
    input  logic [$clog2(OUTPUT_ELEMENTS)-1:0]        wr_col_i,
    input  logic [INPUT_ELEMENTS-1:0]                 wr_data_i,
    output logic                                      wr_err_o
);

    localparam int unsigned COL_W = $clog2(OUTPUT_ELEMENTS);
    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    cim_state_e                state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [INPUT_ELEMENTS-1:0] wl_q;
    logic                      adc_valid_q;
    logic                      wr_err_q;

    logic idle_c;
    logic accept_c;
    logic wr_ok_c;
    logic wr_bad_c;

    // Handshake and write qualification.
    assign idle_c   = (state_q == S_IDLE);
    assign accept_c = wl_valid_i && idle_c;
    assign wr_ok_c  = wr_en_i && idle_c && (32'(wr_col_i) < OUTPUT_ELEMENTS);
    assign wr_bad_c = wr_en_i && !wr_ok_c;

    // Sequencer: precharge, evaluate, convert for CONV_CYCLES, then publish codes.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wl_q        <= '0;
            adc_valid_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            adc_valid_q <= 1'b0;
            if (wr_bad_c) begin
                wr_err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        wl_q    <= wl_bits_i;
                        state_q <= S_PRECHARGE;
                    end
                end
                S_PRECHARGE: begin
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    cnt_q   <= CNT_W'(CONV_CYCLES - 1);
                    state_q <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    adc_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Column array; each column latches its own weights when addressed.
    for (genvar j = 0; j < OUTPUT_ELEMENTS; j++) begin : g_col
        logic col_wr_c;
        assign col_wr_c = wr_ok_c && (wr_col_i == COL_W'(j));

        cim_macro_model_col_adc #(
            .INPUT_ELEMENTS (INPUT_ELEMENTS),
            .ADC_BITS       (ADC_BITS),
            .ADC_SHIFT      (ADC_SHIFT)
        ) u_col (
            .clk       (clk),
            .nrst      (nrst),
            .wr_en_i   (col_wr_c),
            .wr_data_i (wr_data_i),
            .wl_i      (wl_q),
            .eval_i    (state_q == S_EVAL),
            .done_i    (state_q == S_DONE),
            .adc_o     (adc_o[j])
        );
    end

    assign wl_ready_o  = idle_c;
    assign adc_valid_o = adc_valid_q;
    assign wr_err_o    = wr_err_q;

endmodule

// File: tb/tb_cim_macro_model.sv
// Scoreboard bench for cim_macro_model: directed planes, hand-computed ADC codes.
module tb_cim_macro_model;

    logic                  clk;
    logic                  nrst;
    logic [127:0]          wl_bits;
    logic                  wl_valid;
    logic                  wl_ready;
    logic [31:0][3:0]      adc;
    logic                  adc_valid;
    logic                  wr_en;
    logic [4:0]            wr_col;
    logic [127:0]          wr_data;
    logic                  wr_err;

    typedef struct {
        logic [31:0][3:0] codes;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    cim_macro_model dut (
        .clk         (clk),
        .nrst        (nrst),
        .wl_bits_i   (wl_bits),
        .wl_valid_i  (wl_valid),
        .wl_ready_o  (wl_ready),
        .adc_o       (adc),
        .adc_valid_o (adc_valid),
        .wr_en_i     (wr_en),
        .wr_col_i    (wr_col),
        .wr_data_i   (wr_data),
        .wr_err_o    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the index of the last rising edge.
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0][3:0] vec_all(input logic [3:0] c);
        logic [31:0][3:0] v;
        for (int i = 0; i < 32; i++) v[i] = c;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string name, input logic [31:0][3:0] act,
                           input logic [31:0][3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every adc_valid_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (adc_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got pulse expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk_vec("adc_codes", adc, e.codes);
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (wl_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (wl_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%b expected 1", wl_ready);
        end
    endtask

    // Issue one plane; accept edge is cyc+1, pulse expected five edges later.
    task automatic send(input logic [127:0] plane, input logic [31:0][3:0] exp);
        exp_t e;
        wait_ready();
        wl_bits  = plane;
        wl_valid = 1'b1;
        e.codes  = exp;
        e.cyc    = cyc + 6;
        q.push_back(e);
        @(negedge clk);
        wl_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic write_col(input int col, input logic [127:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_col  = 5'(col);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0]     ones;
        logic [127:0]     plane_m12;
        logic [127:0]     w;
        logic [31:0][3:0] v3a;
        logic [31:0][3:0] v3b;
        logic [31:0][3:0] v5;
        int               c0;
        exp_t             e;

        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        wl_bits  = '0;
        wl_valid = 1'b0;
        wr_en    = 1'b0;
        wr_col   = '0;
        wr_data  = '0;
        ones     = '1;
        plane_m12 = '0;
        plane_m12[127:70] = '1;
        plane_m12[45:0]   = '1;

        // Column 0: sum 12 -> 2; column 1: sum 4 -> 1; column 2: sum 2 -> 0.
        v3a = vec_all(4'h8);
        v3a[0] = 4'd2;
        v3a[1] = 4'd1;
        v3a[2] = 4'd0;
        // Same columns under the -12 plane; others -104 saturate to -8.
        v3b = vec_all(4'h8);
        v3b[0] = 4'hF;
        v3b[1] = 4'hF;
        v3b[2] = 4'hF;
        v5 = v3a;
        v5[0] = 4'd7;

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(wl_ready), 1);
        chk("rst_valid", int'(adc_valid), 0);
        chk_vec("rst_adc", adc, vec_all(4'h0));
        chk("rst_wr_err", int'(wr_err), 0);
        nrst = 1'b1;

        // Reset weights are all -1.
        send(ones, vec_all(4'h8));
        send('0, vec_all(4'h0));
        drain();

        // All weights +1: sum 128 saturates to +7.
        for (int j = 0; j < 32; j++) write_col(j, ones);
        send(ones, vec_all(4'h7));
        drain();

        // Rounding and negative shift cases.
        w = '0; w[69:0] = '1; write_col(0, w);
        w = '0; w[65:0] = '1; write_col(1, w);
        w = '0; w[64:0] = '1; write_col(2, w);
        for (int j = 3; j < 32; j++) write_col(j, '0);
        send(ones, v3a);
        send(plane_m12, v3b);
        drain();

        // Valid held high: accepts every six edges.
        wait_ready();
        c0 = cyc;
        wl_bits  = ones;
        wl_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.codes = v3a;
            e.cyc   = c0 + 1 + 6 * k + 5;
            q.push_back(e);
        end
        while (cyc < c0 + 13) @(negedge clk);
        wl_valid = 1'b0;
        drain();

        // Write while converting is dropped and flagged.
        chk("wr_err_clean", int'(wr_err), 0);
        send(ones, v3a);
        repeat (2) @(negedge clk);
        wr_en   = 1'b1;
        wr_col  = 5'd0;
        wr_data = ones;
        @(negedge clk);
        wr_en   = 1'b0;
        chk("wr_err_set", int'(wr_err), 1);
        drain();
        send(ones, v3a);
        drain();
        chk("wr_err_sticky", int'(wr_err), 1);

        // Write and accept in the same idle cycle: evaluation sees the new weights.
        wait_ready();
        wr_en    = 1'b1;
        wr_col   = 5'd0;
        wr_data  = ones;
        wl_bits  = ones;
        wl_valid = 1'b1;
        e.codes  = v5;
        e.cyc    = cyc + 6;
        q.push_back(e);
        @(negedge clk);
        wr_en    = 1'b0;
        wl_valid = 1'b0;
        drain();
        chk("wr_err_still", int'(wr_err), 1);

        // Reset during conversion discards the plane.
        send(ones, v5);
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        q.delete();
        @(negedge clk);
        nrst = 1'b1;
        repeat (8) @(negedge clk);
        chk_vec("midrst_adc", adc, vec_all(4'h0));
        chk("midrst_ready", int'(wl_ready), 1);
        chk("midrst_wr_err", int'(wr_err), 0);
        send(ones, vec_all(4'h8));
        drain();

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
